mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between NREQ cache requesters. Default NREQ=4: index 0 icache0, 1 dcache0, 2 icache1, 3 dcache1.
- Arbitration is round-robin, one transaction outstanding at a time.
- Keeps one LL/SC link register per requester and resolves SC success or failure, so datomic works across cores.
- Sits between the caches and the RAM model.

Parameters:
NREQ, 4, number of requesters (≥2)
PTRW, $clog2(NREQ), width of grant index / round-robin pointer

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
req_ren  in  NREQ  per-requester read request
req_wen  in  NREQ  per-requester write request
req_atomic  in  NREQ  with ren: LL; with wen: SC
req_addr  in  32*NREQ  byte address, requester i at [32i+31:32i]
req_wdata  in  32*NREQ  store data, same packing
req_ready  out  NREQ  one-hot completion pulse
req_rdata  out  32  shared load data / SC result, valid when any req_ready is high
grant  out  NREQ  one-hot; requester currently owning the RAM
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  32  RAM address
ram_store  out  32  RAM write data
ram_load  in  32  RAM read data
ram_ready  in  1  RAM access complete this cycle

Behaviour:
- Reset (async, any state):
  - state=IDLE, rr_ptr=0, all link valid bits=0, latched regs=0.
  - Outputs: grant, req_ready, ram_ren, ram_wen = 0; ram_addr, ram_store, req_rdata = 0.
- Request: requester i is active when ren[i]|wen[i]. If both are set, the write wins.
- Requester contract: hold the request stable until its req_ready pulse; drop it or change it the cycle after.
- State IDLE:
  - Search active requesters starting at rr_ptr, wrapping modulo NREQ; the first found wins, index g.
  - If no requester is active, stay in IDLE.
  - On a win, at the clock edge latch g, op, atomic, addr and wdata.
  - Next state is SCFAIL if the op is SC and (link_valid[g]=0 or link_addr[g]≠addr[31:2]); otherwise ACCESS.
  - No RAM strobes in IDLE. ram_ready in IDLE is ignored.
- State ACCESS:
  - grant[g]=1. Drive ram_ren or ram_wen from the latched op, with ram_addr and ram_store from the latched values.
  - Later changes on the req_* inputs are ignored.
  - Wait any number of cycles for ram_ready.
  - In the cycle ram_ready=1:
    - req_ready[g]=1 (combinational).
    - req_rdata = ram_load for reads; req_rdata = 1 for a successful SC; 0 for a plain write.
    - At the edge: rr_ptr = (g+1) mod NREQ, state=IDLE.
- State SCFAIL (one cycle):
  - grant[g]=1, no RAM strobe.
  - req_ready[g]=1, req_rdata=0.
  - At the edge: rr_ptr=(g+1) mod NREQ, state=IDLE.
- Link registers, updated at the completing edge only:
  - LL completing for requester g: link_addr[g]=addr[31:2], link_valid[g]=1.
  - Any completed RAM write (plain or successful SC): clear link_valid[k] for every k whose link_addr[k]=addr[31:2] and is valid. This includes g itself.
  - An LL and a write never complete on the same edge, because only one transaction is outstanding.
  - A failed SC and any read do not alter other links.
- Throughput and latency:
  - Minimum latency request→req_ready is 2 cycles: IDLE edge, then ACCESS with ram_ready=1.
  - Back-to-back grants take at least 2 cycles each; there is always one IDLE cycle between transactions.
- Fairness: a continuously requesting requester is granted within NREQ transactions.
- Outputs only reach req_ready/req_rdata combinationally from ram_ready/ram_load.
- Reset mid-ACCESS: the transaction is abandoned, no req_ready pulse. The requester re-issues after reset.

Test Plan:
- Single read:
  - Stimulus: ren[1]=1, addr 0x100; RAM returns 0xDEADBEEF after 3 wait cycles.
  - Required: grant=0010 for 4 cycles, ram_ren=1, ram_addr=0x100; req_ready=0010 for one cycle with req_rdata=0xDEADBEEF; rr_ptr=2.
- Contention round-robin:
  - Stimulus: all four requesters hold reads, zero-wait RAM, starting from reset.
  - Required: grant order 0,1,2,3,0; each req_ready 2 cycles apart.
- LL/SC success:
  - Stimulus: dcache0 LL 0x200; then SC 0x200 with data 0x55.
  - Required: ram_wen=1 with ram_store=0x55; req_rdata=1; link_valid[1]=0 afterwards.
- LL/SC interference:
  - Stimulus: dcache0 LL 0x200; dcache1 plain write to 0x200 (byte offset 0x202 also matches); dcache0 SC 0x200.
  - Required: SC goes through SCFAIL, no ram_wen, req_rdata=0, req_ready[1] pulsed one cycle after the grant edge.
- Non-matching write:
  - Stimulus: LL 0x200 by requester 1; write to 0x204 by requester 3; SC 0x200 by requester 1.
  - Required: SC succeeds, req_rdata=1.
- Reset mid-access:
  - Stimulus: assert nRST=0 during ACCESS with ram_ready low.
  - Required: ram_ren, grant and req_ready drop immediately; link regs cleared; after release the arbiter idles until a new request arrives.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin owner of the single RAM port shared by the cache
// requesters, with one outstanding transaction and per-requester LL/SC links.

// One LL/SC link register: set by a completing LL, cleared by any completing
// RAM write to the same word.
module mem_arbiter_link (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        set,
    input  logic        wr,
    input  logic [29:0] waddr,
    output logic        valid,
    output logic [29:0] laddr
);
    // set and wr never fire together: only one transaction completes per edge
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            laddr <= '0;
        end else if (set) begin
            valid <= 1'b1;
            laddr <= waddr;
        end else if (wr && valid && laddr == waddr) begin
            valid <= 1'b0;
        end
    end
endmodule

module mem_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NREQ-1:0]      req_ren,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ-1:0]      req_atomic,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          req_rdata,
    output logic [NREQ-1:0]      grant,
    output logic                 ram_ren,
    output logic                 ram_wen,
    output logic [31:0]          ram_addr,
    output logic [31:0]          ram_store,
    input  logic [31:0]          ram_load,
    input  logic                 ram_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, SCFAIL} state_t;

    // transaction captured at grant time; inputs are ignored afterwards
    typedef struct packed {
        logic        wr;
        logic        atomic;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

    state_t                 state, state_n;
    logic [PTRW-1:0]        rr_ptr, g, win;
    xact_t                  x;
    logic [NREQ-1:0][31:0]  addr_v, wdata_v;
    logic [NREQ-1:0]        active, g_oh;
    logic [NREQ-1:0]        link_v;
    logic [NREQ-1:0][29:0]  link_a;
    logic                   found, sc_ok, go, fin, ll_done, wr_done;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;
    assign active  = req_ren | req_wen;
    assign g_oh    = NREQ'(1) << g;

    // round-robin search starting at rr_ptr, wrapping modulo NREQ
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && active[PTRW'(idx)]) begin
                found = 1'b1;
                win   = PTRW'(idx);
            end
        end
    end

    // an SC may only proceed if the winner still holds a link on that word
    assign sc_ok = link_v[win] && (link_a[win] == addr_v[win][31:2]);

    // next-state and completion decode
    always_comb begin
        state_n = state;
        go      = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    go = 1'b1;
                    if (req_wen[win] && req_atomic[win] && !sc_ok) state_n = SCFAIL;
                    else                                           state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (ram_ready) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
            end
            SCFAIL: begin
                fin     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // port outputs; completion reaches req_ready/req_rdata combinationally
    always_comb begin
        grant     = '0;
        req_ready = '0;
        req_rdata = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        case (state)
            ACCESS: begin
                grant   = g_oh;
                ram_ren = !x.wr;
                ram_wen = x.wr;
                if (ram_ready) begin
                    req_ready = g_oh;
                    if (!x.wr)         req_rdata = ram_load;
                    else if (x.atomic) req_rdata = 32'd1;
                end
            end
            SCFAIL: begin
                grant     = g_oh;
                req_ready = g_oh;
            end
            default: ;
        endcase
    end

    assign ram_addr  = x.addr;
    assign ram_store = x.wdata;

    // state, round-robin pointer and latched transaction
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            rr_ptr <= '0;
            g      <= '0;
            x      <= '0;
        end else begin
            state <= state_n;
            if (fin) rr_ptr <= (g == PTRW'(NREQ - 1)) ? '0 : g + 1'b1;
            if (go) begin
                g        <= win;
                x.wr     <= req_wen[win];
                x.atomic <= req_atomic[win];
                x.addr   <= addr_v[win];
                x.wdata  <= wdata_v[win];
            end
        end
    end

    // links move only on a completing RAM access; SCFAIL never touches them
    assign ll_done = (state == ACCESS) && ram_ready && !x.wr && x.atomic;
    assign wr_done = (state == ACCESS) && ram_ready && x.wr;

    genvar i;
    generate
        for (i = 0; i < NREQ; i++) begin : g_link
            mem_arbiter_link u_link (
                .CLK   (CLK),
                .nRST  (nRST),
                .set   (ll_done && (g == PTRW'(i))),
                .wr    (wr_done),
                .waddr (x.addr[31:2]),
                .valid (link_v[i]),
                .laddr (link_a[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled
// around the falling edge, away from the active rising edge.
module tb_mem_arbiter;
    localparam int N = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [N-1:0]     ren, wen, atm;
    logic [N-1:0][31:0] addr, wdata;
    logic [N-1:0]     rdy, grant;
    logic [31:0]      rdata, ram_addr, ram_store, ram_load;
    logic             ram_ren, ram_wen, ram_ready;
    int               nvec = 0;
    int               nerr = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.NREQ(N)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(ren), .req_wen(wen), .req_atomic(atm),
        .req_addr(addr), .req_wdata(wdata),
        .req_ready(rdy), .req_rdata(rdata), .grant(grant),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready)
    );

    task automatic clr();
        ren = '0; wen = '0; atm = '0; addr = '0; wdata = '0;
        ram_ready = 1'b0; ram_load = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clr();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    // plain zero-wait transaction used to set up link state
    task automatic txn(input int i, input logic w, input logic a,
                       input logic [31:0] ad, input logic [31:0] d);
        @(negedge CLK);
        ren[i] = !w; wen[i] = w; atm[i] = a; addr[i] = ad; wdata[i] = d;
        ram_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        clr();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clr();
        #3;
        nvec++; if (grant !== 4'b0) begin nerr++; $display("FAIL rst_grant: got %b want 0000", grant); end
        nvec++; if (rdy !== 4'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0000", rdy); end
        nvec++; if ({ram_ren, ram_wen} !== 2'b00) begin nerr++; $display("FAIL rst_strobes: got %b want 00", {ram_ren, ram_wen}); end
        nvec++; if ({ram_addr, ram_store, rdata} !== 96'h0) begin nerr++; $display("FAIL rst_data: got %h want 0", {ram_addr, ram_store, rdata}); end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge CLK);
        ren[1] = 1'b1; addr[1] = 32'h100;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            ram_ready = (c == 3); ram_load = 32'hDEADBEEF;
            #1;
            nvec++; if (grant !== 4'b0010) begin nerr++; $display("FAIL rd_grant c%0d: got %b want 0010", c, grant); end
            nvec++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 32'h100) begin nerr++; $display("FAIL rd_ram c%0d: got ren=%b wen=%b addr=%h want 1 0 100", c, ram_ren, ram_wen, ram_addr); end
            nvec++; if (rdy !== ((c == 3) ? 4'b0010 : 4'b0000)) begin nerr++; $display("FAIL rd_ready c%0d: got %b", c, rdy); end
        end
        nvec++; if (rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_data: got %h want deadbeef", rdata); end
        @(negedge CLK);
        clr();
        #1;
        nvec++; if (grant !== 4'b0 || rdy !== 4'b0) begin nerr++; $display("FAIL rd_idle: got grant=%b ready=%b want 0", grant, rdy); end
        // pointer moved to 2: with 0 and 2 both asking, 2 wins
        ren[0] = 1'b1; ren[2] = 1'b1;
        @(negedge CLK);
        ram_ready = 1'b1; ram_load = 32'h2;
        #1;
        nvec++; if (grant !== 4'b0100 || rdy !== 4'b0100) begin nerr++; $display("FAIL rd_rrptr: got grant=%b ready=%b want 0100", grant, rdy); end
        @(negedge CLK);
        clr();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        @(negedge CLK);
        ren = 4'b1111; ram_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp = 4'b0001 << (t % 4);
            @(negedge CLK);
            ram_load = 32'h1000 + t;
            #1;
            nvec++; if (grant !== exp || rdy !== exp || rdata !== 32'h1000 + t) begin nerr++; $display("FAIL rr_grant t%0d: got grant=%b ready=%b data=%h want %b", t, grant, rdy, rdata, exp); end
            @(negedge CLK);
            #1;
            nvec++; if (grant !== 4'b0 || rdy !== 4'b0) begin nerr++; $display("FAIL rr_idle t%0d: got grant=%b ready=%b want 0", t, grant, rdy); end
            if (t == 4) clr();
        end
    endtask

    task automatic test_llsc_success();
        do_reset();
        txn(1, 1'b0, 1'b1, 32'h200, 32'h0);
        @(negedge CLK);
        wen[1] = 1'b1; atm[1] = 1'b1; addr[1] = 32'h200; wdata[1] = 32'h55;
        @(negedge CLK);
        ram_ready = 1'b1;
        #1;
        nvec++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_store !== 32'h55) begin nerr++; $display("FAIL sc_ram: got wen=%b ren=%b store=%h want 1 0 55", ram_wen, ram_ren, ram_store); end
        nvec++; if (rdy !== 4'b0010 || rdata !== 32'd1) begin nerr++; $display("FAIL sc_ok: got ready=%b data=%h want 0010 1", rdy, rdata); end
        @(negedge CLK);
        clr();
        // link consumed by its own SC: a repeat SC must fail
        @(negedge CLK);
        wen[1] = 1'b1; atm[1] = 1'b1; addr[1] = 32'h200; wdata[1] = 32'h66;
        @(negedge CLK);
        #1;
        nvec++; if (grant !== 4'b0010 || ram_wen !== 1'b0 || rdy !== 4'b0010 || rdata !== 32'd0) begin nerr++; $display("FAIL sc_relink: got grant=%b wen=%b ready=%b data=%h want 0010 0 0010 0", grant, ram_wen, rdy, rdata); end
        @(negedge CLK);
        clr();
    endtask

    task automatic test_interference();
        do_reset();
        txn(1, 1'b0, 1'b1, 32'h200, 32'h0);
        txn(3, 1'b1, 1'b0, 32'h202, 32'h77);
        @(negedge CLK);
        wen[1] = 1'b1; atm[1] = 1'b1; addr[1] = 32'h200; wdata[1] = 32'h99;
        @(negedge CLK);
        #1;
        nvec++; if (grant !== 4'b0010 || ram_wen !== 1'b0 || ram_ren !== 1'b0) begin nerr++; $display("FAIL scf_strobe: got grant=%b wen=%b ren=%b want 0010 0 0", grant, ram_wen, ram_ren); end
        nvec++; if (rdy !== 4'b0010 || rdata !== 32'd0) begin nerr++; $display("FAIL scf_resp: got ready=%b data=%h want 0010 0", rdy, rdata); end
        @(negedge CLK);
        clr();
        #1;
        nvec++; if (grant !== 4'b0 || rdy !== 4'b0) begin nerr++; $display("FAIL scf_len: got grant=%b ready=%b want 0", grant, rdy); end
    endtask

    task automatic test_nonmatch();
        do_reset();
        txn(1, 1'b0, 1'b1, 32'h200, 32'h0);
        txn(3, 1'b1, 1'b0, 32'h204, 32'h11);
        @(negedge CLK);
        wen[1] = 1'b1; atm[1] = 1'b1; addr[1] = 32'h200; wdata[1] = 32'h55;
        @(negedge CLK);
        ram_ready = 1'b1;
        #1;
        nvec++; if (ram_wen !== 1'b1 || ram_addr !== 32'h200) begin nerr++; $display("FAIL nm_ram: got wen=%b addr=%h want 1 200", ram_wen, ram_addr); end
        nvec++; if (rdy !== 4'b0010 || rdata !== 32'd1) begin nerr++; $display("FAIL nm_resp: got ready=%b data=%h want 0010 1", rdy, rdata); end
        @(negedge CLK);
        clr();
        // ren and wen together: the write wins
        @(negedge CLK);
        ren[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h300; wdata[0] = 32'hA5;
        @(negedge CLK);
        ram_ready = 1'b1; ram_load = 32'hFFFF;
        #1;
        nvec++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || rdata !== 32'd0 || rdy !== 4'b0001) begin nerr++; $display("FAIL both_wr: got wen=%b ren=%b data=%h ready=%b want 1 0 0 0001", ram_wen, ram_ren, rdata, rdy); end
        @(negedge CLK);
        clr();
    endtask

    task automatic test_reset_mid();
        do_reset();
        txn(1, 1'b0, 1'b1, 32'h200, 32'h0);
        @(negedge CLK);
        ren[2] = 1'b1; addr[2] = 32'h400;
        @(negedge CLK);
        #1;
        nvec++; if (grant !== 4'b0100 || ram_ren !== 1'b1) begin nerr++; $display("FAIL mid_pre: got grant=%b ren=%b want 0100 1", grant, ram_ren); end
        #2;
        nRST = 1'b0;
        ram_ready = 1'b1;
        #1;
        nvec++; if (grant !== 4'b0 || ram_ren !== 1'b0 || rdy !== 4'b0 || ram_addr !== 32'h0) begin nerr++; $display("FAIL mid_rst: got grant=%b ren=%b ready=%b addr=%h want 0", grant, ram_ren, rdy, ram_addr); end
        clr();
        @(negedge CLK);
        nRST = 1'b1;
        ram_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1;
            nvec++; if (grant !== 4'b0 || rdy !== 4'b0 || ram_ren !== 1'b0) begin nerr++; $display("FAIL mid_idle c%0d: got grant=%b ready=%b ren=%b want 0", c, grant, rdy, ram_ren); end
        end
        // link of requester 1 was wiped by reset, so its SC fails
        @(negedge CLK);
        ram_ready = 1'b0;
        wen[1] = 1'b1; atm[1] = 1'b1; addr[1] = 32'h200; wdata[1] = 32'h1;
        @(negedge CLK);
        #1;
        nvec++; if (ram_wen !== 1'b0 || rdy !== 4'b0010 || rdata !== 32'd0) begin nerr++; $display("FAIL mid_link: got wen=%b ready=%b data=%h want 0 0010 0", ram_wen, rdy, rdata); end
        @(negedge CLK);
        clr();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_llsc_success();
        test_interference();
        test_nonmatch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
